// File: rtl/sprite_compositor_pkg.sv
// Shared constants for the sprite compositor: coordinate width, default sprite size,
// ROM offset width and the obj_x/obj_y packing helper.
package sprite_compositor_pkg;

    localparam int unsigned CoordW     = 10;
    localparam int unsigned SprWDef    = 32;
    localparam int unsigned SprHDef    = 48;
    localparam int unsigned HActiveDef = 640;
    localparam int unsigned VActiveDef = 480;
    localparam int unsigned OffW       = 6;
    localparam int unsigned IdW        = 3;

    // LSB of object idx inside a packed per-object coordinate bus.
    function automatic int unsigned obj_lsb(int unsigned idx, int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Scan-address, sprite-memory and pixel/collision signals of the sprite compositor.
// The master drives scan and object state; the slave is the compositor.
interface sprite_compositor_if
    import sprite_compositor_pkg::*;
#(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned ADDR_W  = CoordW
);
    logic [ADDR_W-1:0]         haddress;
    logic [ADDR_W-1:0]         vaddress;
    logic [NUM_OBJ-1:0]        obj_en;
    logic [NUM_OBJ*ADDR_W-1:0] obj_x;
    logic [NUM_OBJ*ADDR_W-1:0] obj_y;
    logic [NUM_OBJ*OffW-1:0]   rom_row;
    logic [NUM_OBJ*OffW-1:0]   rom_col;
    logic [NUM_OBJ-1:0]        rom_bit;
    logic                      collide_dis;
    logic                      collide_clr;
    logic                      pixel_on;
    logic [IdW-1:0]            pixel_id;
    logic                      collide;
    logic [NUM_OBJ-1:0]        frame_hits;

    modport master (
        output haddress, vaddress, obj_en, obj_x, obj_y, rom_bit, collide_dis, collide_clr,
        input  rom_row, rom_col, pixel_on, pixel_id, collide, frame_hits
    );

    modport slave (
        input  haddress, vaddress, obj_en, obj_x, obj_y, rom_bit, collide_dis, collide_clr,
        output rom_row, rom_col, pixel_on, pixel_id, collide, frame_hits
    );

endinterface

// File: rtl/sprite_compositor_hit_test.sv
// Per-object box compare: registers the in-box flag and the row/column offsets
// into that object's sprite memory (stage 1 of the compositor pipeline).
module sprite_compositor_hit_test
    import sprite_compositor_pkg::*;
#(
    parameter int unsigned ADDR_W = CoordW,
    parameter int unsigned SPR_W  = SprWDef,
    parameter int unsigned SPR_H  = SprHDef
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              active_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] h_i,
    input  logic [ADDR_W-1:0] v_i,
    input  logic [ADDR_W-1:0] x_i,
    input  logic [ADDR_W-1:0] y_i,
    output logic              in_box_o,
    output logic [OffW-1:0]   row_o,
    output logic [OffW-1:0]   col_o
);

    localparam logic [ADDR_W:0] SprWC = (ADDR_W + 1)'(SPR_W);
    localparam logic [ADDR_W:0] SprHC = (ADDR_W + 1)'(SPR_H);

    logic [ADDR_W:0]   dx, dy;
    logic              in_box_d, in_box_q;
    logic [OffW-1:0]   row_d, row_q, col_d, col_q;

    // The explicit >= checks stop sprites near the top of the range wrapping to column 0.
    always_comb begin
        dx       = {1'b0, h_i} - {1'b0, x_i};
        dy       = {1'b0, v_i} - {1'b0, y_i};
        in_box_d = en_i & active_i & (h_i >= x_i) & (dx < SprWC) & (v_i >= y_i) & (dy < SprHC);
        row_d    = in_box_d ? dy[OffW-1:0] : '0;
        col_d    = in_box_d ? dx[OffW-1:0] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_box_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            in_box_q <= in_box_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    assign in_box_o = in_box_q;
    assign row_o    = row_q;
    assign col_o    = col_q;

endmodule

// File: rtl/sprite_compositor.sv
// Sprite layer engine: per-object box test, fixed-priority pixel composite,
// sticky player/obstacle collision flag and per-frame hit vector. Latency 2.
module sprite_compositor
    import sprite_compositor_pkg::*;
#(
    parameter int unsigned NUM_OBJ  = 4,
    parameter int unsigned SPR_W    = SprWDef,
    parameter int unsigned SPR_H    = SprHDef,
    parameter int unsigned ADDR_W   = CoordW,
    parameter int unsigned H_ACTIVE = HActiveDef,
    parameter int unsigned V_ACTIVE = VActiveDef
) (
    input logic                 clk,
    input logic                 reset_n,
    sprite_compositor_if.slave  bus
);

    logic                      active;
    logic                      frame_end_d, frame_end_q;
    logic [NUM_OBJ-1:0]        in_box, hit, term;
    logic [NUM_OBJ*OffW-1:0]   row_w, col_w;
    logic                      now;
    logic                      pixel_on_d, pixel_on_q;
    logic [IdW-1:0]            pixel_id_d, pixel_id_q;
    logic                      collide_d, collide_q;
    logic [NUM_OBJ-1:0]        acc_d, acc_q;
    logic [NUM_OBJ-1:0]        frame_hits_d, frame_hits_q;

    assign active      = (bus.haddress < ADDR_W'(H_ACTIVE)) && (bus.vaddress < ADDR_W'(V_ACTIVE));
    assign frame_end_d = (bus.haddress == '0) && (bus.vaddress == ADDR_W'(V_ACTIVE));

    for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
        sprite_compositor_hit_test #(
            .ADDR_W (ADDR_W),
            .SPR_W  (SPR_W),
            .SPR_H  (SPR_H)
        ) u_hit (
            .clk      (clk),
            .reset_n  (reset_n),
            .active_i (active),
            .en_i     (bus.obj_en[i]),
            .h_i      (bus.haddress),
            .v_i      (bus.vaddress),
            .x_i      (bus.obj_x[obj_lsb(i, ADDR_W) +: ADDR_W]),
            .y_i      (bus.obj_y[obj_lsb(i, ADDR_W) +: ADDR_W]),
            .in_box_o (in_box[i]),
            .row_o    (row_w[obj_lsb(i, OffW) +: OffW]),
            .col_o    (col_w[obj_lsb(i, OffW) +: OffW])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= frame_end_d;
        end
    end

    // Stage 2: memory bits arrive combinationally for the registered offsets.
    assign hit  = in_box & bus.rom_bit;
    assign now  = hit[0] & (|hit[NUM_OBJ-1:1]) & ~bus.collide_dis;
    assign term = {hit[NUM_OBJ-1:1] & {(NUM_OBJ - 1){hit[0]}}, 1'b0};

    // Scan downwards so the lowest set index is the final assignment.
    always_comb begin
        pixel_on_d = |hit;
        pixel_id_d = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pixel_id_d = IdW'(i);
            end
        end
    end

    always_comb begin
        collide_d    = now | (collide_q & ~bus.collide_clr);
        acc_d        = acc_q | term;
        frame_hits_d = frame_hits_q;
        if (frame_end_q) begin
            frame_hits_d = acc_q | term;
            acc_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_on_q   <= 1'b0;
            pixel_id_q   <= '0;
            collide_q    <= 1'b0;
            acc_q        <= '0;
            frame_hits_q <= '0;
        end else begin
            pixel_on_q   <= pixel_on_d;
            pixel_id_q   <= pixel_id_d;
            collide_q    <= collide_d;
            acc_q        <= acc_d;
            frame_hits_q <= frame_hits_d;
        end
    end

    assign bus.rom_row    = row_w;
    assign bus.rom_col    = col_w;
    assign bus.pixel_on   = pixel_on_q;
    assign bus.pixel_id   = pixel_id_q;
    assign bus.collide    = collide_q;
    assign bus.frame_hits = frame_hits_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: a behavioural model fills a scoreboard queue as
// scan addresses are driven; entries are popped and compared when the pipeline emits them.
module tb_sprite_compositor;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sprite_compositor_if #(.NUM_OBJ(N), .ADDR_W(10)) bus ();

    sprite_compositor #(
        .NUM_OBJ  (N),
        .SPR_W    (32),
        .SPR_H    (48),
        .ADDR_W   (10),
        .H_ACTIVE (640),
        .V_ACTIVE (480)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [N-1:0] inb;
        logic         fend;
        logic [23:0]  row;
        logic [23:0]  col;
        logic         pon;
        logic [2:0]   pid;
        logic         coll;
        logic [3:0]   fh;
    } rec_t;

    int         ox[N];
    int         oy[N];
    int         mode[N];
    logic [N-1:0] en;
    rec_t       q[$];
    rec_t       pend;
    bit         pend_v;
    logic       m_coll;
    logic [3:0] m_acc, m_fh;
    int         n_chk = 0;
    int         n_pass = 0;

    // Sprite memories: 0 = blank, 1 = solid, 2 = stripe pattern.
    function automatic logic pat(int m, logic [5:0] r, logic [5:0] c);
        if (m == 1) return 1'b1;
        if (m == 2) return r[0] ^ c[1];
        return 1'b0;
    endfunction

    always_comb begin
        bus.rom_bit = '0;
        for (int i = 0; i < N; i++) begin
            bus.rom_bit[i] = pat(mode[i], bus.rom_row[i*6 +: 6], bus.rom_col[i*6 +: 6]);
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic rec_t model(int h, int v);
        rec_t r;
        r.inb = '0; r.row = '0; r.col = '0; r.pon = 1'b0; r.pid = '0; r.coll = 1'b0; r.fh = '0;
        r.fend = (h == 0) && (v == 480);
        for (int i = 0; i < N; i++) begin
            int dx = h - ox[i];
            int dy = v - oy[i];
            if (en[i] && h < 640 && v < 480 && dx >= 0 && dx < 32 && dy >= 0 && dy < 48) begin
                r.inb[i]        = 1'b1;
                r.row[i*6 +: 6] = 6'(dy);
                r.col[i*6 +: 6] = 6'(dx);
            end
        end
        return r;
    endfunction

    task automatic drive_obj();
        bus.obj_en = en;
        for (int i = 0; i < N; i++) begin
            bus.obj_x[i*10 +: 10] = 10'(ox[i]);
            bus.obj_y[i*10 +: 10] = 10'(oy[i]);
        end
    endtask

    // Called at a falling edge: check, drive one scan address, update the model.
    task automatic step(int h, int v, logic clr, logic dis);
        rec_t r;
        logic [N-1:0] hits;
        logic [3:0] term;
        logic now;
        if (pend_v) begin
            chk("rom_row", bus.rom_row, pend.row);
            chk("rom_col", bus.rom_col, pend.col);
        end
        if (q.size() > 0) begin
            r = q.pop_front();
            chk("pixel_on", bus.pixel_on, r.pon);
            chk("pixel_id", bus.pixel_id, r.pid);
            chk("collide", bus.collide, r.coll);
            chk("frame_hits", bus.frame_hits, r.fh);
        end
        bus.haddress    = 10'(h);
        bus.vaddress    = 10'(v);
        bus.collide_clr = clr;
        bus.collide_dis = dis;
        drive_obj();
        if (pend_v) begin
            for (int i = 0; i < N; i++) begin
                hits[i] = pend.inb[i] & pat(mode[i], pend.row[i*6 +: 6], pend.col[i*6 +: 6]);
            end
            pend.pon = |hits;
            pend.pid = '0;
            for (int i = N - 1; i >= 0; i--) if (hits[i]) pend.pid = 3'(i);
            now    = hits[0] & (|hits[3:1]) & ~dis;
            m_coll = now | (m_coll & ~clr);
            term   = {hits[3:1] & {3{hits[0]}}, 1'b0};
            if (pend.fend) begin
                m_fh  = m_acc | term;
                m_acc = '0;
            end else begin
                m_acc = m_acc | term;
            end
            pend.coll = m_coll;
            pend.fh   = m_fh;
            q.push_back(pend);
        end
        pend   = model(h, v);
        pend_v = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        repeat (n) step(700, 0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        pend_v = 1'b0;
        m_coll = 1'b0;
        m_acc  = '0;
        m_fh   = '0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_pixel_on"}, bus.pixel_on, 0);
        chk({tag, "_pixel_id"}, bus.pixel_id, 0);
        chk({tag, "_collide"}, bus.collide, 0);
        chk({tag, "_frame_hits"}, bus.frame_hits, 0);
        chk({tag, "_rom_row"}, bus.rom_row, 0);
        chk({tag, "_rom_col"}, bus.rom_col, 0);
    endtask

    initial begin
        en = '0;
        for (int i = 0; i < N; i++) begin
            ox[i] = 0; oy[i] = 0; mode[i] = 0;
        end
        bus.haddress = '0; bus.vaddress = '0; bus.collide_clr = 1'b0; bus.collide_dis = 1'b0;
        drive_obj();
        model_reset();

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Single player sprite, offsets and 2-cycle pixel latency.
        en = 4'b0001; ox[0] = 200; oy[0] = 200; mode[0] = 1;
        step(205, 210, 1'b0, 1'b0);
        chk("t1_rom_col", bus.rom_col[5:0], 5);
        chk("t1_rom_row", bus.rom_row[5:0], 10);
        step(700, 0, 1'b0, 1'b0);
        chk("t1_pixel_on", bus.pixel_on, 1);
        chk("t1_pixel_id", bus.pixel_id, 0);
        step(200, 200, 1'b0, 1'b0); step(231, 247, 1'b0, 1'b0);
        step(232, 247, 1'b0, 1'b0); step(199, 200, 1'b0, 1'b0);
        step(231, 248, 1'b0, 1'b0);
        mode[0] = 2;
        for (int k = 0; k < 6; k++) step(200 + k, 201, 1'b0, 1'b0);
        idle(2);

        // Overlap of player and object 2: priority and sticky collision.
        en = 4'b0101; ox[0] = 290; oy[0] = 90; ox[2] = 295; oy[2] = 95;
        mode[0] = 1; mode[2] = 1;
        step(300, 100, 1'b0, 1'b0);
        step(700, 0, 1'b0, 1'b0);
        chk("t2_pixel_on", bus.pixel_on, 1);
        chk("t2_pixel_id", bus.pixel_id, 0);
        chk("t2_collide_rise", bus.collide, 1);
        idle(3);
        chk("t2_collide_sticky", bus.collide, 1);
        step(700, 0, 1'b1, 1'b0);
        chk("t2_collide_clr", bus.collide, 0);
        step(300, 100, 1'b0, 1'b0);
        step(700, 0, 1'b1, 1'b0);
        chk("t2_set_wins", bus.collide, 1);
        step(700, 0, 1'b1, 1'b0);
        chk("t2_clr_again", bus.collide, 0);
        en = 4'b0100;
        step(300, 100, 1'b0, 1'b0);
        idle(2);

        // Right edge of active region and no wrap from the top of the coordinate range.
        en = 4'b0010; ox[1] = 630; oy[1] = 0; mode[1] = 1;
        step(639, 10, 1'b0, 1'b0);
        step(640, 10, 1'b0, 1'b0);
        chk("t3_col639_on", bus.pixel_on, 1);
        chk("t3_col639_id", bus.pixel_id, 1);
        step(700, 0, 1'b0, 1'b0);
        chk("t3_col640_off", bus.pixel_on, 0);
        ox[1] = 1020;
        for (int k = 0; k < 4; k++) step(k, 10, 1'b0, 1'b0);
        idle(2);

        // Frame accumulator: overlap in frame N only.
        en = 4'b0000;
        step(0, 480, 1'b0, 1'b0);
        idle(2);
        en = 4'b1001; ox[0] = 100; oy[0] = 100; ox[3] = 110; oy[3] = 110;
        mode[0] = 1; mode[3] = 1;
        step(115, 115, 1'b0, 1'b0);
        step(0, 480, 1'b0, 1'b0);
        idle(2);
        chk("t4_frame_n", bus.frame_hits, 4'b1000);
        en = 4'b0001;
        step(115, 115, 1'b0, 1'b0);
        step(0, 480, 1'b0, 1'b0);
        idle(2);
        chk("t4_frame_n1", bus.frame_hits, 4'b0000);

        // Collision disabled: pixels and frame record unaffected, flag held low.
        step(700, 0, 1'b1, 1'b0);
        en = 4'b1001;
        step(115, 115, 1'b0, 1'b1);
        step(700, 0, 1'b0, 1'b1);
        chk("t5_pixel_on", bus.pixel_on, 1);
        chk("t5_collide", bus.collide, 0);
        step(0, 480, 1'b0, 1'b0);
        idle(2);
        chk("t5_frame_hits", bus.frame_hits, 4'b1000);

        // Pseudo-random scan over two overlapping sprites with random clear/disable.
        en = 4'b0011; ox[0] = 200; oy[0] = 200; mode[0] = 2;
        ox[1] = 215; oy[1] = 220; mode[1] = 1;
        for (int k = 0; k < 60; k++) begin
            step(int'($urandom_range(190, 255)), int'($urandom_range(190, 275)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));
        end
        idle(2);

        // Asynchronous reset mid-line while collide is set.
        en = 4'b0101; ox[0] = 290; oy[0] = 90; ox[2] = 295; oy[2] = 95;
        mode[0] = 1; mode[2] = 1;
        step(300, 100, 1'b0, 1'b0);
        step(301, 100, 1'b0, 1'b0);
        step(700, 0, 1'b0, 1'b0);
        chk("t6_pre_collide", bus.collide, 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("t6_async");
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(300, 100, 1'b0, 1'b0);
        step(700, 0, 1'b0, 1'b0);
        chk("t6_resume_on", bus.pixel_on, 1);
        chk("t6_resume_collide", bus.collide, 1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised sprite layer engine for the VGA pipeline. Given the current scan address, it tests up to NUM_OBJ positioned sprites and fetches their bitmap bits from external combinational sprite memories. It resolves a fixed priority between overlapping sprites and emits one monochrome pixel with the winning object ID. It also detects player-versus-obstacle overlap: a sticky collision flag plus a per-frame hit vector. It sits between the vga timing generator and the colour output stage, and replaces the hand-written per-sprite compare logic in the top level.

## Interface

Parameters:

- NUM_OBJ, 4: number of sprite channels; object 0 is the player. Range 2..8.
- SPR_W, 32: sprite width in pixels (power of two not required).
- SPR_H, 48: sprite height in pixels.
- ADDR_W, 10: width of scan and position coordinates.
- H_ACTIVE, 640: visible columns.
- V_ACTIVE, 480: visible rows.

Ports:

- clk  in  1  pixel clock (25 MHz divided clock).
- reset_n  in  1  asynchronous, active-low reset.
- haddress  in  ADDR_W  current scan column.
- vaddress  in  ADDR_W  current scan row.
- obj_en  in  NUM_OBJ  per-object enable.
- obj_x  in  NUM_OBJ*ADDR_W  packed left edges; object i occupies [i*ADDR_W +: ADDR_W].
- obj_y  in  NUM_OBJ*ADDR_W  packed top edges, same packing.
- rom_row  out  NUM_OBJ*6  registered row offset per object into its sprite memory.
- rom_col  out  NUM_OBJ*6  registered column offset per object.
- rom_bit  in  NUM_OBJ  combinational sprite-memory bit for the current rom_row/rom_col.
- collide_dis  in  1  debug: suppresses collision setting.
- collide_clr  in  1  single-cycle clear of the sticky flag.
- pixel_on  out  1  composited pixel.
- pixel_id  out  3  winning object index; 0 when pixel_on is 0.
- collide  out  1  sticky collision flag.
- frame_hits  out  NUM_OBJ  objects that overlapped the player during the last complete frame; bit 0 is always 0.

## Operation

- **Stage 1** (registered at edge k, using inputs present before edge k):
  - dx_i = haddress − obj_x_i and dy_i = vaddress − obj_y_i, computed at ADDR_W+1 bits unsigned.
  - in_box_i = obj_en_i & active & (haddress ≥ obj_x_i) & (dx_i < SPR_W) & (vaddress ≥ obj_y_i) & (dy_i < SPR_H).
  - active = haddress < H_ACTIVE & vaddress < V_ACTIVE.
  - rom_row_i / rom_col_i ← dy_i / dx_i truncated to 6 bits when in_box_i; otherwise 0.
  - in_box is registered alongside the offsets.
  - Sprites whose left edge is near the top of the coordinate range do not wrap to column 0.
- **Stage 2** (registered at edge k+1):
  - hit_i = in_box_i & rom_bit_i.
  - pixel_on ← |hit.
  - pixel_id ← lowest-index set hit (the player wins).
- **Collision** (evaluated in stage 2):
  - now = hit_0 & |hit[NUM_OBJ−1:1] & ~collide_dis.
  - collide ← now | (collide & ~collide_clr). Set wins over a simultaneous clear.
- **Frame accumulator:**
  - acc |= {hit[NUM_OBJ−1:1] & {hit_0}, 1'b0} each stage-2 cycle.
  - Frame end is the cycle stage 1 sees haddress==0 && vaddress==V_ACTIVE. On the matching stage-2 cycle: frame_hits ← acc (including that cycle's term), and acc ← 0.
- **Reset** (async, any time, including mid-frame): all pipeline registers, rom_row, rom_col, pixel_on, pixel_id, collide, acc and frame_hits go to 0. The first pixel after release is valid 2 cycles later.

## Timing

- Latency is 2 cycles from scan address to pixel_on/pixel_id/collide. Downstream hsync/vsync must be delayed by 2 cycles to match.
- rom_row/rom_col are valid 1 cycle after the address. rom_bit must settle combinationally within the same cycle.
- Throughput is one pixel per clock with no stalls.
- obj_x, obj_y and obj_en may change at any cycle. They take effect from the next sampled address; there is no frame-boundary shadowing.
- collide_clr is sampled in stage 2 timing. A clear asserted while collide_dis=1 clears the flag normally.

## Structure

- The shared package holds the coordinate width, the default sprite dimensions, and the packing helper constants for obj_x/obj_y slicing.
- One natural sub-module is sprite_hit_test: a per-object box compare and offset register, instantiated NUM_OBJ times with a generate loop.
- Priority encode and collision logic stay in the parent.

## Test plan

- Single object 0 at (200,200), sprite all-ones, scan (205,210) → rom_col=5, rom_row=10 after 1 cycle; pixel_on=1, pixel_id=0 after 2 cycles.
- Objects 0 and 2 both covering (300,100), both bits 1 → pixel_id=0, collide rises on the same cycle and stays high until collide_clr; a clear in the same cycle as a new overlap leaves collide=1.
- Object 1 at x=630, SPR_W=32, scan column 639 → hit; scan column 640 → pixel_on=0 (inactive region). Object at x=1020 → never visible at column 0..3.
- Overlap of player with object 3 in frame N only → frame_hits=4'b1000 after the frame-end cycle of N; frame_hits=0 after frame N+1.
- collide_dis=1 with player/obstacle overlap → pixel output is normal, collide stays 0, and frame_hits still records the overlap.
- reset_n pulsed low mid-line while collide=1 → all outputs 0 immediately (asynchronously); normal pixels resume 2 cycles after release.
